// File: rtl/ctrl_stat_regs.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_stat_regs
// Brief    : Event counter bank with host-triggered coherent snapshot shadows.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_stat_regs #(
   parameter int NUM_CNT = 8,
   parameter int CNT_W   = 32,
   parameter int CNT_SAT = 0
) (
   input  logic               up_clk,
   input  logic               up_rst,
   input  logic               ctrl_up_cs_stat,
   input  logic               ctrl_up_wr,
   input  logic               ctrl_up_rd,
   input  logic [31:0]        ctrl_up_addr,
   input  logic [31:0]        ctrl_up_data_wr,
   output logic [31:0]        ctrl_up_data_rd_stat,
   input  logic [NUM_CNT-1:0] stat_inc
);

   localparam logic [15:0] c_SIG         = 16'h5A7C;
   localparam logic [5:0]  c_WORD_CTRL   = 6'd0;
   localparam logic [5:0]  c_WORD_STATUS = 6'd1;
   localparam int          c_WORD_CNT0   = 16;

   logic [5:0]       w_word;
   logic             w_wr_vld;
   logic             w_rd_vld;
   logic             w_snap;
   logic             w_clr;
   logic [31:0]      w_rd_word;
   logic             w_unused;

   logic [CNT_W-1:0] live_q   [NUM_CNT];
   logic [CNT_W-1:0] live_d   [NUM_CNT];
   logic [CNT_W-1:0] shadow_q [NUM_CNT];
   logic [CNT_W-1:0] shadow_d [NUM_CNT];
   logic [CNT_W-1:0] w_inc    [NUM_CNT];
   logic [7:0]       snap_cnt_q;
   logic [7:0]       snap_cnt_d;
   logic [31:0]      rd_q;
   logic [31:0]      rd_d;

   function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] v, input logic en);
      if (!en)
         return v;
      if (&v)
         return (CNT_SAT != 0) ? v : '0;
      return v + CNT_W'(1);
   endfunction

   assign w_word   = ctrl_up_addr[7:2];
   assign w_wr_vld = ctrl_up_cs_stat & ctrl_up_wr;
   // A simultaneous write wins, so the read is dropped entirely.
   assign w_rd_vld = ctrl_up_cs_stat & ctrl_up_rd & ~ctrl_up_wr;
   assign w_snap   = w_wr_vld & (w_word == c_WORD_CTRL) & ctrl_up_data_wr[0];
   assign w_clr    = w_wr_vld & (w_word == c_WORD_CTRL) & ctrl_up_data_wr[1];
   assign w_unused = ^{ctrl_up_addr[31:8], ctrl_up_addr[1:0], ctrl_up_data_wr[31:2]};

   // The shadow always takes the incremented value so a same-cycle event lands
   // in the closing period on SNAP, or the new period on a bare CLR.
   always_comb begin
      for (int i = 0; i < NUM_CNT; i++) begin
         w_inc[i]    = f_inc(live_q[i], stat_inc[i]);
         live_d[i]   = w_inc[i];
         shadow_d[i] = shadow_q[i];
         if (w_snap)
            shadow_d[i] = w_inc[i];
         if (w_clr)
            live_d[i] = w_snap ? '0 : CNT_W'(stat_inc[i]);
      end
   end

   assign snap_cnt_d = w_snap ? snap_cnt_q + 8'd1 : snap_cnt_q;

   always_comb begin
      w_rd_word = 32'h0;
      if (w_word == c_WORD_STATUS) begin
         w_rd_word = {c_SIG, 8'(NUM_CNT), snap_cnt_q};
      end else begin
         for (int i = 0; i < NUM_CNT; i++) begin
            if (w_word == 6'(c_WORD_CNT0 + i))
               w_rd_word = 32'(shadow_q[i]);
         end
      end
      rd_d = w_rd_vld ? w_rd_word : rd_q;
   end

   always_ff @(posedge up_clk) begin
      if (up_rst) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            live_q[i]   <= '0;
            shadow_q[i] <= '0;
         end
         snap_cnt_q <= 8'h0;
         rd_q       <= 32'h0;
      end else begin
         live_q     <= live_d;
         shadow_q   <= shadow_d;
         snap_cnt_q <= snap_cnt_d;
         rd_q       <= rd_d;
      end
   end

   assign ctrl_up_data_rd_stat = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_stat_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_stat_regs
// Brief    : Directed bench for ctrl_stat_regs, default plus 4-bit wrap/sat builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_stat_regs;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs;
   logic        wr;
   logic        rd;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [7:0]  inc;
   logic [31:0] rd_main;
   logic [31:0] rd_wrap;
   logic [31:0] rd_sat;

   int n_vec = 0;
   int n_err = 0;

   int          q_sel [$];
   logic [31:0] q_exp [$];
   string       q_tag [$];

   always #5 clk = ~clk;

   ctrl_stat_regs dut (
      .up_clk               (clk),
      .up_rst               (rst),
      .ctrl_up_cs_stat      (cs),
      .ctrl_up_wr           (wr),
      .ctrl_up_rd           (rd),
      .ctrl_up_addr         (addr),
      .ctrl_up_data_wr      (wdata),
      .ctrl_up_data_rd_stat (rd_main),
      .stat_inc             (inc)
   );

   ctrl_stat_regs #(.NUM_CNT(2), .CNT_W(4), .CNT_SAT(0)) dut_wrap (
      .up_clk               (clk),
      .up_rst               (rst),
      .ctrl_up_cs_stat      (cs),
      .ctrl_up_wr           (wr),
      .ctrl_up_rd           (rd),
      .ctrl_up_addr         (addr),
      .ctrl_up_data_wr      (wdata),
      .ctrl_up_data_rd_stat (rd_wrap),
      .stat_inc             (inc[1:0])
   );

   ctrl_stat_regs #(.NUM_CNT(2), .CNT_W(4), .CNT_SAT(1)) dut_sat (
      .up_clk               (clk),
      .up_rst               (rst),
      .ctrl_up_cs_stat      (cs),
      .ctrl_up_wr           (wr),
      .ctrl_up_rd           (rd),
      .ctrl_up_addr         (addr),
      .ctrl_up_data_wr      (wdata),
      .ctrl_up_data_rd_stat (rd_sat),
      .stat_inc             (inc[1:0])
   );

   function automatic logic [31:0] obs(input int sel);
      case (sel)
         1:       return rd_wrap;
         2:       return rd_sat;
         default: return rd_main;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_vec++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   // One bus cycle: inputs change on the falling edge, outputs settle 1 ns after rise.
   task automatic drive(input logic c, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d, input logic [7:0] i);
      @(negedge clk);
      cs = c; wr = w; rd = r; addr = a; wdata = d; inc = i;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
   endtask

   task automatic pulse(input logic [7:0] m, input int n);
      for (int k = 0; k < n; k++)
         drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, m);
   endtask

   task automatic wr_ctrl(input logic [31:0] d, input logic [7:0] i);
      drive(1'b1, 1'b1, 1'b0, 32'h0, d, i);
   endtask

   task automatic rd_chk(input logic [31:0] a, input int sel, input logic [31:0] e, input string tag);
      q_sel.push_back(sel);
      q_exp.push_back(e);
      q_tag.push_back(tag);
      drive(1'b1, 1'b0, 1'b1, a, 32'h0, 8'h0);
      check(q_tag.pop_front(), obs(q_sel.pop_front()), q_exp.pop_front());
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0;
      addr = 32'h0; wdata = 32'h0; inc = 8'h0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rd", rd_main, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      rd_chk(32'h04, 0, 32'h5A7C_0800, "status_default");
      rd_chk(32'h40, 0, 32'h0,         "shadow0_reset");

      pulse(8'h04, 5);
      wr_ctrl(32'h1, 8'h0);
      rd_chk(32'h48, 0, 32'd5, "shadow2_after_snap");
      rd_chk(32'h44, 0, 32'd0, "shadow1_zero");
      pulse(8'h04, 3);
      rd_chk(32'h48, 0, 32'd5, "shadow2_stable");
      rd_chk(32'h04, 0, 32'h5A7C_0801, "snap_cnt_1");

      wr_ctrl(32'h3, 8'h0);
      pulse(8'h01, 9);
      wr_ctrl(32'h3, 8'h01);
      rd_chk(32'h40, 0, 32'd10, "snapclr_same_cycle");
      wr_ctrl(32'h1, 8'h0);
      rd_chk(32'h40, 0, 32'd0, "post_clr_snap");

      wr_ctrl(32'h2, 8'h02);
      wr_ctrl(32'h1, 8'h0);
      rd_chk(32'h44, 0, 32'd1, "clr_event_counted");

      drive(1'b0, 1'b0, 1'b1, 32'h48, 32'h0, 8'h0);
      check("cs0_read_hold", rd_main, 32'd1);
      drive(1'b1, 1'b1, 1'b1, 32'h00, 32'h1, 8'h0);
      check("wr_rd_hold", rd_main, 32'd1);
      rd_chk(32'h04, 0, 32'h5A7C_0806, "wr_rd_write_done");
      rd_chk(32'h7C, 0, 32'h0, "unmapped_cnt_idx");
      rd_chk(32'h04, 0, 32'h5A7C_0806, "status_again");
      rd_chk(32'h00, 0, 32'h0, "ctrl_reads_zero");

      wr_ctrl(32'h2, 8'h0);
      pulse(8'h01, 17);
      wr_ctrl(32'h1, 8'h0);
      rd_chk(32'h40, 1, 32'd1,  "w4_wrap");
      rd_chk(32'h40, 2, 32'd15, "w4_sat");
      rd_chk(32'h40, 0, 32'd17, "w32_17");

      pulse(8'h08, 4);
      @(negedge clk);
      rst = 1'b1; cs = 1'b1; wr = 1'b1; rd = 1'b0;
      addr = 32'h0; wdata = 32'h1; inc = 8'hFF;
      @(posedge clk);
      #1;
      check("rst_mid_rd", rd_main, 32'h0);
      @(negedge clk);
      rst = 1'b0; cs = 1'b0; wr = 1'b0; inc = 8'h0;
      rd_chk(32'h40, 0, 32'h0, "rst_shadow0");
      rd_chk(32'h04, 0, 32'h5A7C_0800, "rst_snap_cnt");
      wr_ctrl(32'h1, 8'h0);
      rd_chk(32'h4C, 0, 32'h0, "rst_live3");
      rd_chk(32'h40, 0, 32'h0, "rst_live0");

      for (int k = 0; k < 254; k++)
         wr_ctrl(32'h1, 8'h0);
      rd_chk(32'h04, 0, 32'h5A7C_08FF, "snap_cnt_255");
      wr_ctrl(32'h1, 8'h0);
      rd_chk(32'h04, 0, 32'h5A7C_0800, "snap_cnt_wrap");
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ctrl_stat_regs.md
Name: ctrl_stat_regs

Overview:
- Statistics counter bank on the CPU control path, directly downstream of the CPU bus decoder.
- Consumes the decoder's registered stat-space strobe, address, write data and read/write strobes, and drives the stat-space read-data bus back to the decoder's read mux.
- Counts single-cycle event pulses from the tester datapath (tx/rx frames, errors, etc.).
- Holds a host-triggered snapshot so multi-counter reads are coherent.

Parameters:
NUM_CNT, 8, number of event counters (1..48)
CNT_W, 32, counter width in bits (1..32); read data zero-extended to 32
CNT_SAT, 0, 1 = counters saturate at all-ones; 0 = counters wrap to 0

Ports:
up_clk  input  1  system clock; all logic on rising edge
up_rst  input  1  synchronous reset, active-high
ctrl_up_cs_stat  input  1  stat-space select (registered by decoder, held between accesses)
ctrl_up_wr  input  1  write strobe, one cycle per access
ctrl_up_rd  input  1  read strobe, one cycle per access
ctrl_up_addr  input  32  byte address; only [7:2] decoded
ctrl_up_data_wr  input  32  write data
ctrl_up_data_rd_stat  output  32  read data (registered)
stat_inc  input  NUM_CNT  per-counter increment pulse; bit i adds 1 to counter i in that cycle

Behaviour:
Clock and reset:
- One clock, up_clk.
- Reset is synchronous, active-high, on up_rst.
- On reset: all live counters = 0, all shadows = 0, snap_cnt = 0, ctrl_up_data_rd_stat = 32'h0.

Access qualification:
- Access valid only when ctrl_up_cs_stat = 1 in the same cycle as ctrl_up_wr or ctrl_up_rd.
- ctrl_up_wr and ctrl_up_rd both high: write performed; read ignored, read-data register unchanged.

Address map (word index = ctrl_up_addr[7:2]):
- 0x00 CTRL (write-only; reads 0)
  - bit0 SNAP: copy all live counters to shadows.
  - bit1 CLR: zero all live counters.
  - Other bits ignored.
- 0x04 STATUS (read-only): [31:16] = 16'h5A7C signature; [15:8] = NUM_CNT; [7:0] = snap_cnt.
  - snap_cnt increments on each SNAP write and wraps 255 -> 0.
- 0x40 + 4*i (i < NUM_CNT): shadow counter i, read-only.
- Writes to read-only or unmapped addresses: no effect.
- Reads of unmapped addresses, CTRL, or i >= NUM_CNT: 32'h0.

Read timing:
- ctrl_up_data_rd_stat is loaded on the rising edge where a valid read is sampled.
- Valid from the next cycle; held until the next valid read or reset.
- Total host read latency: 2 up_clk from the host's up_rd (1 cycle decoder + 1 cycle here).
- Reads never disturb counters or shadows.

Counters:
- Each cycle, live counter i += stat_inc[i].
- All counters update in parallel.
- At all-ones with an increment pending:
  - CNT_SAT = 1: stays all-ones.
  - CNT_SAT = 0: wraps to 0.

Snapshot and clear (write to CTRL):
- SNAP:
  - shadow[i] <= live[i] + stat_inc[i] for the write cycle, saturating/wrapping as above, so no event is lost.
  - Shadows change only on SNAP or reset.
- CLR without SNAP: live[i] <= stat_inc[i] (an event in the clear cycle counts in the new period).
- SNAP and CLR together (data 0x3): shadow = pre-clear value including the same-cycle event; live <= 0.
  - The same-cycle event is counted exactly once, in the shadow.

Reset mid-operation:
- up_rst wins over any access or increment in the same cycle.
- All state returns to reset values.

Test Plan:
- Reset then read STATUS (addr 0x04) with defaults -> 32'h5A7C_0800; read 0x40 -> 0; every read appears exactly 1 cycle after ctrl_up_rd.
- Pulse stat_inc[2] 5 times, write CTRL=0x1, read 0x48 -> 5; read 0x44 -> 0; further pulses without SNAP leave 0x48 at 5; STATUS[7:0] = 1.
- Assert stat_inc[0] in the same cycle as CTRL=0x3 write after 9 prior pulses -> shadow0 = 10; next SNAP with no new events -> shadow0 = 0.
- CTRL=0x2 with stat_inc[1] high that cycle, then SNAP -> shadow1 = 1.
- CNT_W=4: CNT_SAT=0, 17 pulses then SNAP -> 1; CNT_SAT=1, 17 pulses then SNAP -> 15.
- Read with ctrl_up_cs_stat=0 -> ctrl_up_data_rd_stat unchanged; read 0x7C with NUM_CNT=8 -> 0; 256 SNAP writes -> snap_cnt = 0; up_rst asserted mid-count -> all reads return 0.
